// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory.
//
// Handshake semantics:
//   Request channel: the master drives imem_req/imem_addr. A request is
//   accepted in exactly the cycles where imem_req && imem_ready.
//   Response channel: the slave pulses imem_rvalid for one cycle per
//   accepted request, with imem_rdata valid in that cycle. The pulse comes
//   at least one cycle after acceptance, and responses return in request
//   order. imem_rvalid carries no ready. The master always takes the
//   response.
//
// Signals:
//   imem_req     master -> slave  request valid
//   imem_addr    master -> slave  word address, bits [1:0] are zero
//   imem_ready   slave -> master  request accepted this cycle (with req)
//   imem_rvalid  slave -> master  response word valid this cycle
//   imem_rdata   slave -> master  response instruction word
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32IM pipeline. This stage owns the PC and
// keeps at most one request outstanding to instruction memory. It loads the
// IF/ID register. If a word returns while the pipeline is stalled, the word
// is parked in a one-entry skid buffer (S_HOLD), so the word is not lost.
// A redirect flushes IF/ID. If a response is still in flight when the
// redirect arrives, that response is marked for dropping, so no word from
// the wrong path ever reaches IF/ID.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            fetch_stage_if.master (request/response to imem)
//   stall_i         hold IF/ID and stop advancing
//   redirect_i      flush and refetch from redirect_pc_i. Overrides stall_i.
//   redirect_pc_i   redirect target. Bits [1:0] are ignored.
//   if_id_inst      registered instruction (NOP_INST when not valid)
//   if_id_pc        registered PC of if_id_inst
//   if_id_valid     if_id_inst is a real instruction
//   dbg_state       current FSM state (0=S_REQ, 1=S_WAIT, 2=S_HOLD)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic [31:0]          if_id_inst,
    output logic [31:0]          if_id_pc,
    output logic                 if_id_valid,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;        // address of the outstanding or next request
    logic        drop;      // in-flight response belongs to the wrong path
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;

    logic [31:0] pc_next4;
    logic [31:0] target;
    logic        deliver;   // returning word goes straight into IF/ID
    logic        hold_release;

    assign pc_next4 = pc + 32'd4;
    assign target   = {redirect_pc_i[31:2], 2'b00};

    assign deliver = (state == S_WAIT) && imem.imem_rvalid && !drop &&
                     !redirect_i && !stall_i;

    assign hold_release = (state == S_HOLD) && !redirect_i && !stall_i;

    assign dbg_state = state;

    // The next request goes out in the same cycle a word is delivered. This
    // back-to-back issue gives one instruction per cycle on a zero-wait
    // memory. The request is gated with rst_n, so no request is made while
    // the stage is in reset.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        if (rst_n) begin
            case (state)
                S_REQ: begin
                    imem.imem_req = !redirect_i;
                end
                S_WAIT: begin
                    if (deliver) begin
                        imem.imem_req  = 1'b1;
                        imem.imem_addr = pc_next4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            buf_inst    <= 32'h0;
            buf_pc      <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_i) begin
                        pc <= target;
                    end else if (imem.imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop) begin
                            // Stale word from before an earlier redirect.
                            // A redirect in this same cycle still moves
                            // pc to the new target.
                            drop  <= 1'b0;
                            state <= S_REQ;
                            if (redirect_i) begin
                                pc <= target;
                            end
                        end else if (redirect_i) begin
                            pc    <= target;
                            state <= S_REQ;
                        end else if (stall_i) begin
                            buf_inst <= imem.imem_rdata;
                            buf_pc   <= pc;
                            pc       <= pc_next4;
                            state    <= S_HOLD;
                        end else begin
                            pc    <= pc_next4;
                            state <= imem.imem_ready ? S_WAIT : S_REQ;
                        end
                    end else if (redirect_i) begin
                        // The response cannot be cancelled. Drop it when
                        // it arrives. pc already points at the new target.
                        drop <= 1'b1;
                        pc   <= target;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc    <= target;
                        state <= S_REQ;
                    end else if (!stall_i) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase

            // IF/ID register
            if (redirect_i) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end else if (stall_i) begin
                // hold current contents
            end else if (deliver) begin
                if_id_valid <= 1'b1;
                if_id_inst  <= imem.imem_rdata;
                if_id_pc    <= pc;
            end else if (hold_release) begin
                if_id_valid <= 1'b1;
                if_id_inst  <= buf_inst;
                if_id_pc    <= buf_pc;
            end else begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32IM core. It owns the program counter, issues word requests to instruction memory over a request/response handshake, and loads the IF/ID pipeline register. The immediate generator and decoder consume that register, and the block's branch/jump redirect and hazard stall inputs come from the EX stage and the hazard unit. It holds at most one outstanding memory request and uses a one-entry skid buffer, so no fetched word is lost during stalls.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when it holds no valid instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address; bits [1:0] always 0.
- imem_ready  in  1  a request is accepted in a cycle where imem_req && imem_ready.
- imem_rvalid  in  1  response valid, at least 1 cycle after acceptance, in order.
- imem_rdata  in  32  response instruction word.
- stall_i  in  1  hold IF/ID and stop advancing.
- redirect_i  in  1  flush and refetch from redirect_pc_i; priority over stall_i.
- redirect_pc_i  in  32  target; bits [1:0] forced to 0.
- if_id_inst  out  32  registered instruction.
- if_id_pc  out  32  registered PC of if_id_inst.
- if_id_valid  out  1  if_id_inst is a real instruction.

## Operation
- Registers: pc (address of the outstanding or next request), state, drop flag, buf_inst/buf_pc, and the IF/ID outputs. pc+4 wraps modulo 2^32.
- States: S_REQ (present request), S_WAIT (one request outstanding), S_HOLD (word buffered while stalled).
- S_REQ, imem_req=1, imem_addr=pc:
  - redirect_i: imem_req forced to 0; pc<=target; stay in S_REQ.
  - else imem_ready: go to S_WAIT.
- S_WAIT, imem_req=0 by default:
  - rvalid && drop: discard the word; drop<=0; go to S_REQ.
  - rvalid && redirect_i: discard the word; pc<=target; go to S_REQ.
  - rvalid && stall_i: buf<={rdata,pc}; pc<=pc+4; go to S_HOLD.
  - rvalid otherwise: IF/ID<={rdata,pc,1}; pc<=pc+4. imem_req=1 and imem_addr=pc+4 combinationally in the same cycle; next state is S_WAIT if imem_ready, else S_REQ.
  - !rvalid && redirect_i: drop<=1; pc<=target; stay in S_WAIT. A repeated redirect updates pc and leaves drop at 1.
- S_HOLD, imem_req=0:
  - redirect_i: discard the buffer; pc<=target; go to S_REQ.
  - stall_i: hold.
  - else: IF/ID<={buf_inst,buf_pc,1}; go to S_REQ.
- IF/ID update rule, in priority order:
  1. redirect_i: valid<=0, inst<=NOP_INST; if_id_pc unchanged.
  2. stall_i: hold.
  3. A word is loaded this cycle: load it.
  4. Otherwise: valid<=0, inst<=NOP_INST.
- Reset values: state=S_REQ, pc=RESET_PC, drop=0, buf=0, if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0. imem_req=0 while rst_n=0, and 1 in the first cycle after release.
- Ordering guarantee: no instruction enters IF/ID out of program order. No wrong-path word is delivered after a redirect.

## Timing
- Zero-wait memory (ready=1, rvalid exactly 1 cycle after acceptance):
  - Request for RESET_PC in cycle 0 after release.
  - if_id_valid=1 with inst@RESET_PC from cycle 2.
  - Sustained throughput is 1 instruction per cycle.
- Redirect asserted in cycle N: IF/ID is a bubble in N+1.
  - Target request in N+1, or when the dropped response returns if one is outstanding.
  - With zero-wait memory, the target instruction is valid in IF/ID at N+3.
- Exit from stall via S_HOLD: buffered word enters IF/ID on the release edge; next request the following cycle, which costs one bubble.
- imem_req/imem_addr depend combinationally on imem_rvalid, stall_i and redirect_i. imem_ready and imem_rvalid never combinationally affect any other output.
- rst_n asserted mid-operation clears state immediately. A response returning after reset release for a pre-reset request does not occur: the memory is reset by the same rst_n.

## Test plan
- Zero-wait memory, program at 0x0 = 0x00500093, 0x00A00113, 0x002081B3 -> IF/ID shows pc 0x0, 0x4, 0x8 on consecutive cycles from cycle 2; valid stays 1.
- stall_i held for 3 cycles while the response for 0x4 arrives -> IF/ID holds pc 0x0 and the buffer holds 0x4. After release, IF/ID=0x4, then a single bubble, then 0x8. No request is issued during the stall.
- Memory with a 3-cycle response latency, redirect_i to 0x100 in the cycle after acceptance of 0x8 -> the word for 0x8 is discarded and the next imem_addr is 0x100. IF/ID never shows pc 0x8; the next valid pc is 0x100.
- redirect_i and stall_i asserted together in S_HOLD -> IF/ID goes to valid=0 with inst 0x00000013, the buffer is dropped, and the next request is the target.
- redirect_pc_i=0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC; the following fetch address wraps to 0x0000_0000.
- rst_n pulsed low mid-stream, with imem_ready held low for 2 cycles after release -> all outputs return to reset values asynchronously. imem_req stays 1 with addr RESET_PC until accepted.
